// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the chunked (multi-cycle) arithmetic blocks.
//   - state_t        : control state of a chunked operation (IDLE/RUN/DONE)
//   - clog2()        : ceiling log2, usable in constant expressions
//   - counter_width(): width of a chunk index counter (never less than 1 bit)
//   - chunk_cfg_ok() : legality check for a WIDTH/CHUNK pairing
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // A single-chunk block still needs a one-bit index so the counter stays a
  // real signal instead of a zero-width vector.
  function automatic int counter_width(input int nchunk);
    return (clog2(nchunk) < 1) ? 1 : clog2(nchunk);
  endfunction

  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage : adder_pkg

// File: rtl/chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
//   Combinational CHUNK-bit ripple-carry slice.
//   Ports:
//     a, b   in  CHUNK  slice operands
//     cin    in  1      carry into bit 0
//     sum    out CHUNK  slice sum
//     cout   out 1      carry out of the slice MSB
//     c_msb  out 1      carry into the slice MSB (for signed overflow)
// ---------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // carry[i] is the carry into bit i; carry[CHUNK] leaves the slice.
  logic [CHUNK:0] carry;

  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no
    // path can leave it unassigned and infer a latch.
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule : chunk_adder

// File: rtl/chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder
//   Multi-cycle WIDTH-bit adder. One CHUNK-bit ripple slice is reused for
//   NCHUNK = WIDTH/CHUNK cycles, the carry passing between cycles through a
//   register. Valid/ready handshake on both sides; one operation in flight.
//
//   Optional feature (macro CHUNKED_ADD_SUB_EN): adds port 'sub'; when set on
//   accept the block computes a - b (B inverted, initial carry forced to 1).
//   Without the macro the block is add-only and 'cin' is always used.
//
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      synchronous active-high reset
//     in_valid   in   1      operands valid
//     in_ready   out  1      operands accepted (high only in IDLE)
//     a, b       in   WIDTH  operands
//     cin        in   1      carry-in
//     sub        in   1      subtract select (CHUNKED_ADD_SUB_EN only)
//     out_valid  out  1      result valid (high only in DONE)
//     out_ready  in   1      consumer takes result
//     sum        out  WIDTH  result, modulo 2^WIDTH
//     cout       out  1      unsigned carry out of bit WIDTH-1
//     ovf        out  1      signed overflow
// ---------------------------------------------------------------------------
module chunked_seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = counter_width(NCHUNK);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
  end

  state_t            state;
  logic [KW-1:0]     k;
  logic              carry;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;

  // Operand B and initial carry as seen by the datapath at accept time.
  logic [WIDTH-1:0]  b_eff;
  logic              c_init;

`ifdef CHUNKED_ADD_SUB_EN
  // a - b == a + ~b + 1; cout then reads as "no borrow".
  assign b_eff  = sub ? ~b : b;
  assign c_init = sub ? 1'b1 : cin;
`else
  assign b_eff  = b;
  assign c_init = cin;
`endif

  // Slice mux: the chunk index selects which CHUNK bits feed the adder.
  logic [31:0]       base;
  logic [CHUNK-1:0]  a_slice;
  logic [CHUNK-1:0]  b_slice;
  logic [CHUNK-1:0]  s_slice;
  logic              s_cout;
  logic              s_cmsb;

  assign base    = 32'(k) * 32'(CHUNK);
  assign a_slice = a_r[base +: CHUNK];
  assign b_slice = b_r[base +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a     (a_slice),
    .b     (b_slice),
    .cin   (carry),
    .sum   (s_slice),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  // Single control/datapath process; all outputs are registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      k         <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is 1 throughout IDLE, so in_valid alone means accept.
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b_eff;
            carry    <= c_init;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          sum[base +: CHUNK] <= s_slice;
          carry              <= s_cout;
          if (k == K_LAST) begin
            // The last slice holds bit WIDTH-1: its carries give cout/ovf.
            cout      <= s_cout;
            ovf       <= s_cout ^ s_cmsb;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end

        DONE: begin
          // A new in_valid here is not looked at; it is taken next cycle
          // from IDLE, keeping in_ready a plain registered state decode.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule : chunked_seq_adder

// File: tb/tb_chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_seq_adder
//   Directed tests on a 16/4 instance plus a randomised sweep that drives the
//   16/4, 16/1 and 16/16 instances in lock-step against an a+b+cin model.
// ---------------------------------------------------------------------------
module tb_chunked_seq_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_ready;

  logic        in_ready,     out_valid,     cout,     ovf;
  logic [15:0] sum;
  logic        in_ready_c1,  out_valid_c1,  cout_c1,  ovf_c1;
  logic [15:0] sum_c1;
  logic        in_ready_c16, out_valid_c16, cout_c16, ovf_c16;
  logic [15:0] sum_c16;

  int checks;
  int errors;

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef CHUNKED_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunked_seq_adder #(.WIDTH(16), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c1),
    .a(a), .b(b), .cin(cin),
`ifdef CHUNKED_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid_c1), .out_ready(out_ready),
    .sum(sum_c1), .cout(cout_c1), .ovf(ovf_c1)
  );

  chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) u_dut_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c16),
    .a(a), .b(b), .cin(cin),
`ifdef CHUNKED_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid_c16), .out_ready(out_ready),
    .sum(sum_c16), .cout(cout_c16), .ovf(ovf_c16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one op on the 16/4 instance, wait for the result, check it, then
  // release it with a one-cycle out_ready pulse.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcin, input logic tsub,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input string name);
    int cyc;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    // Operands may change freely after the accepting edge.
    a = ~ta; b = ~tb; cin = ~tcin;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc != 4) begin
      errors++;
      $display("FAIL %s latency: got %0d want 4", name, cyc);
    end
    checks++;
    if (sum !== es || cout !== ec || ovf !== eo) begin
      errors++;
      $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, es, ec, eo);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000 ||
        cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b want 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
  endtask

  task automatic test_add();
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_pos_ovf");
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "add_cin");
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_neg_ovf");
    run_op(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ripple_all");
  endtask

  task automatic test_backpressure();
    int cyc;
    a = 16'h0F0F; b = 16'h1010; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    // Pulse in_valid with different operands throughout RUN.
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_run_in_ready: got %b want 0 (cycle %0d)", in_ready, cyc);
      end
      in_valid = ~in_valid;
      a = 16'hFFFF; b = 16'hFFFF;
      step();
      cyc++;
    end
    checks++;
    if (cyc != 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 4", cyc);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h1F1F || cout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got out_valid=%b in_ready=%b sum=%h cout=%b want 1 0 1f1f 0 (cycle %0d)",
                 out_valid, in_ready, sum, cout, i);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h1F1F) begin
      errors++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b sum=%h want 0 1 1f1f",
               out_valid, in_ready, sum);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    checks++;
    if (sum !== 16'h0003) begin
      errors++;
      $display("FAIL b2b_first: got sum=%h want 0003", sum);
    end
    // New op offered in the same cycle the result is taken.
    a = 16'h0100; b = 16'h0200; in_valid = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got in_ready=%b want 0", in_ready);
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc != 4 || sum !== 16'h0300) begin
      errors++;
      $display("FAIL b2b_second: got latency=%0d sum=%h want 4 0300", cyc, sum);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: got out_valid=%b in_ready=%b sum=%h cout=%b want 0 1 0000 0",
               out_valid, in_ready, sum, cout);
    end
    run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, "after_rst");
  endtask

`ifdef CHUNKED_ADD_SUB_EN
  task automatic test_sub();
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    // cin must be ignored when subtracting.
    run_op(16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0, "sub_cin_ignored");
  endtask
`endif

  // Sweep: same random op into the CHUNK=4/1/16 instances, model a+b+cin.
  task automatic test_sweep();
    logic [15:0] ra, rb, b_eff, es;
    logic        rc, rs, c0, ec, eo;
    logic [16:0] full;
    int          lat4, lat1, lat16;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
`ifdef CHUNKED_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      b_eff = rs ? ~rb : rb;
      c0    = rs ? 1'b1 : rc;
      full  = {1'b0, ra} + {1'b0, b_eff} + {16'h0000, c0};
      es    = full[15:0];
      ec    = full[16];
      eo    = (ra[15] == b_eff[15]) && (es[15] != ra[15]);

      a = ra; b = rb; cin = rc; sub = rs; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat4 = -1; lat1 = -1; lat16 = -1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        step();
        if (out_valid === 1'b1     && lat4  < 0) lat4  = cyc;
        if (out_valid_c1 === 1'b1  && lat1  < 0) lat1  = cyc;
        if (out_valid_c16 === 1'b1 && lat16 < 0) lat16 = cyc;
        if (lat4 >= 0 && lat1 >= 0 && lat16 >= 0) break;
      end
      checks++;
      if (lat4 != 4 || sum !== es || cout !== ec || ovf !== eo) begin
        errors++;
        if (errors < 20)
          $display("FAIL sweep_c4 op%0d a=%h b=%h cin=%b sub=%b: got lat=%0d sum=%h cout=%b ovf=%b want 4 %h %b %b",
                   n, ra, rb, rc, rs, lat4, sum, cout, ovf, es, ec, eo);
      end
      checks++;
      if (lat1 != 16 || sum_c1 !== es || cout_c1 !== ec || ovf_c1 !== eo) begin
        errors++;
        if (errors < 20)
          $display("FAIL sweep_c1 op%0d a=%h b=%h cin=%b sub=%b: got lat=%0d sum=%h cout=%b ovf=%b want 16 %h %b %b",
                   n, ra, rb, rc, rs, lat1, sum_c1, cout_c1, ovf_c1, es, ec, eo);
      end
      checks++;
      if (lat16 != 1 || sum_c16 !== es || cout_c16 !== ec || ovf_c16 !== eo) begin
        errors++;
        if (errors < 20)
          $display("FAIL sweep_c16 op%0d a=%h b=%h cin=%b sub=%b: got lat=%0d sum=%h cout=%b ovf=%b want 1 %h %b %b",
                   n, ra, rb, rc, rs, lat16, sum_c16, cout_c16, ovf_c16, es, ec, eo);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;

    test_reset();
    test_add();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef CHUNKED_ADD_SUB_EN
    test_sub();
`endif
    test_sweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_chunked_seq_adder
